phv_rr_arbiter: RTL
===================

Name: phv_rr_arbiter

Overview:
- Round-robin arbiter sharing one stage PHV input between NUM_SRC requesters, e.g. parser output and recirculation path.
- Sits directly upstream of a stage: drives the stage's phv_in/phv_in_valid and obeys the stage's ready.
- Provides a quiesce control (arb_en/idle) so control-path table writes can be sequenced against an empty input.
- Keeps per-source accept counters for debug.

Parameters:
- PHV_LEN, 48*8+32*8+16*8+256, PHV width in bits.
- NUM_SRC, 2, number of requesters; legal range 2..4.
- CNT_WIDTH, 32, width of each per-source accept counter.

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- src_phv  in  NUM_SRC*PHV_LEN  flattened PHVs; source i occupies bits [i*PHV_LEN +: PHV_LEN].
- src_valid  in  NUM_SRC  per-source valid.
- src_ready  out  NUM_SRC  per-source ready.
- phv_out  out  PHV_LEN  PHV to stage phv_in.
- phv_out_valid  out  1  to stage phv_in_valid.
- stage_ready_in  in  1  from stage stage_ready_out.
- arb_en  in  1  1 = grant allowed; 0 = stop accepting new PHVs.
- idle  out  1  1 when arb_en=0 and no PHV is held in the output register.
- grant_id  out  2  index of the source that was last accepted.
- accept_cnt  out  NUM_SRC*CNT_WIDTH  per-source accepted-PHV counters.

Behaviour:
- Single clock domain; synchronous active-low reset on aresetn.
- Reset values:
  - phv_out = 0, phv_out_valid = 0, grant_id = 0, accept_cnt = 0.
  - Round-robin pointer rr_ptr = 0.
  - idle = 1 while arb_en = 0.
  - src_ready = 0 while aresetn = 0.
- Output register:
  - out_free = ~phv_out_valid | stage_ready_in.
  - Output transfer = phv_out_valid & stage_ready_in.
- Grant selection (combinational):
  - Search src_valid starting at rr_ptr, increasing index, wrapping modulo NUM_SRC.
  - First asserted source is gnt.
  - No valid source means no grant.
- Ready:
  - src_ready[i] = arb_en & out_free & (gnt == i) & any_valid.
  - At most one bit of src_ready is high per cycle.
  - src_ready may depend combinationally on src_valid; it does not depend on any upstream ready.
- Accept (src_valid[gnt] & src_ready[gnt]), effective next edge:
  - phv_out <= src_phv[gnt]; phv_out_valid <= 1.
  - grant_id <= gnt.
  - rr_ptr <= (gnt+1) mod NUM_SRC.
  - accept_cnt[gnt] increments, wrapping at 2^CNT_WIDTH-1 to 0.
- Transfer without a new accept: phv_out_valid <= 0; phv_out holds its value.
- Simultaneous transfer and accept:
  - New PHV is loaded in the same cycle.
  - phv_out_valid stays 1, giving full throughput of 1 PHV/cycle.
- Stall: while phv_out_valid = 1 and stage_ready_in = 0:
  - phv_out and phv_out_valid hold.
  - All src_ready = 0.
  - rr_ptr holds.
- Latency: 1 cycle from accept to phv_out_valid.
- Fairness:
  - With all sources continuously valid and no stall, grants rotate 0,1,..,NUM_SRC-1,0.
  - A waiting source is served within NUM_SRC accepts.
- Quiesce:
  - arb_en falling blocks new accepts from that cycle.
  - A PHV already in the output register still drains normally.
  - idle = ~arb_en & ~phv_out_valid (combinational).
  - arb_en rising resumes arbitration from the current rr_ptr.
- Reset mid-operation:
  - A held PHV is discarded (phv_out_valid = 0).
  - Counters and rr_ptr clear.
  - No src_ready is asserted during the reset cycle.
- Source protocol: a source must hold src_phv/src_valid stable until accepted. The arbiter does not re-arbitrate away from a granted source unless that source drops valid; such a drop is a source-protocol violation.

Test Plan:
- Reset, then src_valid=2'b11 continuously, stage_ready_in=1, src0 PHV=0xA, src1 PHV=0xB -> phv_out sequence A,B,A,B with phv_out_valid=1 every cycle from cycle 2; after 8 accepts accept_cnt = {4,4}.
- src_valid=2'b01 only, 5 cycles -> 5 consecutive src0 accepts; rr_ptr alternates 1→(0 selected)→1; src_ready[1]=0 throughout.
- Output holds PHV=0xA, stage_ready_in=0 for 3 cycles with both sources valid -> phv_out stays 0xA, src_ready=0; stage_ready_in=1 releases the PHV and accepts the next PHV (src1) in the same cycle.
- arb_en=0 while phv_out_valid=1, stage_ready_in=1 -> PHV transfers next edge, idle=1 the following cycle, no src_ready; arb_en=1 -> arbitration restarts at the stored rr_ptr.
- Preload accept_cnt[0] near wrap (drive 2^CNT_WIDTH accepts with CNT_WIDTH=4 build) -> counter reads 15 then 0.
- Assert aresetn=0 for 1 cycle while phv_out_valid=1 under stall -> phv_out_valid=0, counters 0, rr_ptr=0; the first post-reset grant goes to src0 when both sources are valid.

Source files
------------

// File: rtl/phv_rr_arbiter.sv
// phv_rr_arbiter: round-robin arbiter that shares one stage PHV input
// between NUM_SRC requesters (e.g. parser output and recirculation).
// One-entry output register, 1 PHV/cycle throughput, quiesce control
// (arb_en/idle) and per-source accept counters for debug.
module phv_rr_arbiter #(
   parameter int unsigned PHV_LEN   = 48*8+32*8+16*8+256,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                           axis_clk,
   input  logic                           aresetn,
   input  logic [NUM_SRC*PHV_LEN-1:0]     src_phv,
   input  logic [NUM_SRC-1:0]             src_valid,
   output logic [NUM_SRC-1:0]             src_ready,
   output logic [PHV_LEN-1:0]             phv_out,
   output logic                           phv_out_valid,
   input  logic                           stage_ready_in,
   input  logic                           arb_en,
   output logic                           idle,
   output logic [1:0]                     grant_id,
   output logic [NUM_SRC*CNT_WIDTH-1:0]   accept_cnt
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PHV_LEN-1:0]   phv_q,      phv_d;
   logic                 vld_q,      vld_d;
   logic [1:0]           gid_q,      gid_d;
   logic [1:0]           rr_ptr_q,   rr_ptr_d;
   logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_SRC];

   // ------------------------------------------------------------------
   // Combinational arbitration signals
   // ------------------------------------------------------------------
   logic [3:0]           valid_ext;
   logic [2:0]           idx;
   logic [1:0]           gnt;
   logic                 any_valid;
   logic                 out_free;
   logic                 xfer;
   logic                 accept;
   logic [PHV_LEN-1:0]   phv_sel;
   logic [1:0]           gnt_next_ptr;

   assign out_free = ~vld_q | stage_ready_in;
   assign xfer     = vld_q & stage_ready_in;

   // Search src_valid from rr_ptr upward, wrapping modulo NUM_SRC; the
   // valid vector is zero-extended to 4 bits so a 2-bit index is always legal.
   always_comb begin
      valid_ext = '0;
      valid_ext[NUM_SRC-1:0] = src_valid;
      idx       = '0;
      gnt       = '0;
      any_valid = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         idx = {1'b0, rr_ptr_q} + 3'(k);
         if (idx >= 3'(NUM_SRC)) begin
            idx = idx - 3'(NUM_SRC);
         end
         if (!any_valid && valid_ext[idx[1:0]]) begin
            any_valid = 1'b1;
            gnt       = idx[1:0];
         end
      end
   end

   // Grant is only usable when enabled, out of reset and with room downstream.
   assign accept = any_valid & arb_en & out_free & aresetn;

   // Per-source ready: one-hot on the granted source, never during reset.
   always_comb begin
      src_ready = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         src_ready[i] = accept & (gnt == 2'(i));
      end
   end

   // Mux the granted source's PHV.
   always_comb begin
      phv_sel = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (gnt == 2'(i)) begin
            phv_sel = src_phv[i*PHV_LEN +: PHV_LEN];
         end
      end
   end

   assign gnt_next_ptr = (gnt == 2'(NUM_SRC-1)) ? 2'd0 : gnt + 2'd1;

   // Next-state for output register, pointer and counters.
   always_comb begin
      phv_d    = phv_q;
      vld_d    = vld_q;
      gid_d    = gid_q;
      rr_ptr_d = rr_ptr_q;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (accept) begin
         // A new accept also covers the simultaneous-transfer case: the
         // register is reloaded and valid stays high.
         phv_d    = phv_sel;
         vld_d    = 1'b1;
         gid_d    = gnt;
         rr_ptr_d = gnt_next_ptr;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (gnt == 2'(i)) begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end else if (xfer) begin
         vld_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge axis_clk) begin
      if (!aresetn) begin
         phv_q    <= '0;
         vld_q    <= 1'b0;
         gid_q    <= '0;
         rr_ptr_q <= '0;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         phv_q    <= phv_d;
         vld_q    <= vld_d;
         gid_q    <= gid_d;
         rr_ptr_q <= rr_ptr_d;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Flatten the counters onto the debug port.
   always_comb begin
      accept_cnt = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         accept_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end

   assign phv_out       = phv_q;
   assign phv_out_valid = vld_q;
   assign grant_id      = gid_q;
   assign idle          = ~arb_en & ~vld_q;

   // Structural invariants.
   a_ready_onehot : assert property (@(posedge axis_clk) $onehot0(src_ready));
   a_ptr_range    : assert property (@(posedge axis_clk) disable iff (!aresetn)
                                     32'(rr_ptr_q) < NUM_SRC);

endmodule
